hazard_stall_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage datapath. It sits beside the EX-stage forwarding logic and covers the hazards that forwarding cannot fix.
- It stalls IF/ID on load-use and branch-operand hazards, inserts bubbles into ID/EX, and freezes the whole pipe while data memory is busy.
- It flushes IF/ID on a taken branch or a jump resolved in ID.
- A small FSM holds multi-cycle stalls, so stall length does not depend on frozen stage registers.

---
 rtl/hazard_stall_unit_pkg.sv | 20 ++
 rtl/hazard_stall_unit_if.sv | 48 ++++
 rtl/hazard_stall_unit_detect.sv | 49 ++++
 rtl/hazard_stall_unit.sv | 125 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared encodings and constants for the hazard stall unit
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    MEMWAIT = 2'd2
  } stall_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [1:0] STALL_N0 = 2'd0;
  localparam logic [1:0] STALL_N1 = 2'd1;
  localparam logic [1:0] STALL_N2 = 2'd2;

  function automatic logic [1:0] max_n(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - pipeline-to-hazard-unit bundle; HAZARD_PERF_CNT_EN adds perf counters
interface hazard_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] ID_rs;
  logic [REG_ADDR_W-1:0] ID_rt;
  logic                  ID_UsesRt;
  logic                  ID_Branch;
  logic                  Branch_Taken;
  logic                  Jump;
  logic                  EX_MemRead;
  logic                  EX_RegWrite;
  logic [REG_ADDR_W-1:0] EX_rt;
  logic [REG_ADDR_W-1:0] EX_rd;
  logic                  MEM_MemRead;
  logic [REG_ADDR_W-1:0] MEM_rd;
  logic                  Mem_Busy;

  logic                  PCWrite;
  logic                  IF_ID_Write;
  logic                  ID_EX_Bubble;
  logic                  Pipe_Freeze;
  logic                  IF_Flush;
  logic [1:0]            Stall_State;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]           Stall_Cycles;
  logic [31:0]           Flush_Count;
`endif

  modport master (
    output ID_rs, ID_rt, ID_UsesRt, ID_Branch, Branch_Taken, Jump,
           EX_MemRead, EX_RegWrite, EX_rt, EX_rd, MEM_MemRead, MEM_rd, Mem_Busy,
    input  PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze, IF_Flush, Stall_State
`ifdef HAZARD_PERF_CNT_EN
    , input Stall_Cycles, Flush_Count
`endif
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UsesRt, ID_Branch, Branch_Taken, Jump,
           EX_MemRead, EX_RegWrite, EX_rt, EX_rd, MEM_MemRead, MEM_rd, Mem_Busy,
    output PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze, IF_Flush, Stall_State
`ifdef HAZARD_PERF_CNT_EN
    , output Stall_Cycles, Flush_Count
`endif
  );

endinterface

// File: rtl/hazard_stall_unit_detect.sv
// rtl/hazard_stall_unit_detect.sv - combinational hazard classifier (hit and stall length)
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_usesrt_i,
  input  logic                  id_branch_i,
  input  logic                  ex_memread_i,
  input  logic                  ex_regwrite_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  mem_memread_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  output logic                  hit_o,
  output logic [1:0]            n_o
);

  // A producer matches when it writes a real register that ID reads; $zero never matches.
  function automatic logic reg_match(
    input logic [REG_ADDR_W-1:0] r,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rt,
    input logic                  uses_rt
  );
    return (r != REG_ADDR_W'(REG_ZERO)) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  logic lu_hit;
  logic ba_hit;
  logic bm_hit;

  assign lu_hit = ex_memread_i && reg_match(ex_rt_i, id_rs_i, id_rt_i, id_usesrt_i);
  assign ba_hit = id_branch_i && ex_regwrite_i && !ex_memread_i &&
                  reg_match(ex_rd_i, id_rs_i, id_rt_i, id_usesrt_i);
  assign bm_hit = id_branch_i && mem_memread_i &&
                  reg_match(mem_rd_i, id_rs_i, id_rt_i, id_usesrt_i);

  // Longest required stall wins when several hazard classes fire together.
  always_comb begin
    n_o = STALL_N0;
    if (ba_hit || bm_hit) n_o = STALL_N1;
    if (lu_hit) n_o = max_n(n_o, id_branch_i ? STALL_N2 : STALL_N1);
    hit_o = lu_hit || ba_hit || bm_hit;
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - stall/flush/freeze FSM for the 5-stage pipe; HAZARD_PERF_CNT_EN adds perf counters
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_STALL  = 2
) (
  input logic     Clk,
  input logic     Reset,
  hazard_if.slave hz
);

  localparam int CNT_W = (MAX_STALL > 1) ? $clog2(MAX_STALL) : 1;

  stall_state_e     state_q, state_d;
  stall_state_e     saved_q, saved_d;
  stall_state_e     cur_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;
  logic [1:0]       stall_n;
  logic             pc_w, ifid_w, bubble, freeze, flush;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_detect (
    .id_rs_i       (hz.ID_rs),
    .id_rt_i       (hz.ID_rt),
    .id_usesrt_i   (hz.ID_UsesRt),
    .id_branch_i   (hz.ID_Branch),
    .ex_memread_i  (hz.EX_MemRead),
    .ex_regwrite_i (hz.EX_RegWrite),
    .ex_rt_i       (hz.EX_rt),
    .ex_rd_i       (hz.EX_rd),
    .mem_memread_i (hz.MEM_MemRead),
    .mem_rd_i      (hz.MEM_rd),
    .hit_o         (hit),
    .n_o           (stall_n)
  );

  // State, stall counter and the state parked during a memory wait.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and output decode; leaving MEMWAIT behaves as the saved state in the same cycle.
  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    cnt_d     = cnt_q;
    pc_w      = 1'b1;
    ifid_w    = 1'b1;
    bubble    = 1'b0;
    freeze    = 1'b0;
    flush     = 1'b0;
    cur_state = (state_q == MEMWAIT) ? saved_q : state_q;

    if (hz.Mem_Busy) begin
      freeze  = 1'b1;
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      state_d = MEMWAIT;
      saved_d = cur_state;
    end else begin
      case (cur_state)
        STALL: begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          bubble = 1'b1;
          if (cnt_q != '0) begin
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = (cnt_q == CNT_W'(1)) ? RUN : STALL;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          if (hit) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            bubble = 1'b1;
            if (stall_n > STALL_N1) begin
              cnt_d   = CNT_W'(stall_n - STALL_N1);
              state_d = STALL;
            end
          end else begin
            flush = hz.Branch_Taken || hz.Jump;
          end
        end
      endcase
    end
  end

  assign hz.PCWrite      = Reset & pc_w;
  assign hz.IF_ID_Write  = Reset & ifid_w;
  assign hz.ID_EX_Bubble = ~Reset | bubble;
  assign hz.Pipe_Freeze  = Reset & freeze;
  assign hz.IF_Flush     = Reset & flush;
  assign hz.Stall_State  = Reset ? state_q : RUN;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cyc_q, flush_cnt_q;

  // Saturating counters of lost cycles and flushes.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((bubble || freeze) && (stall_cyc_q != '1)) stall_cyc_q <= stall_cyc_q + 32'd1;
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign hz.Stall_Cycles = stall_cyc_q;
  assign hz.Flush_Count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed plus randomized check of hazard_stall_unit against a cycle model
module tb_hazard_stall_unit;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  hazard_if #(.REG_ADDR_W(5)) bus ();

  hazard_stall_unit #(.REG_ADDR_W(5), .MAX_STALL(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .hz    (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: how many more forced stall cycles are owed, and whether memory is holding us.
  int          m_stall_left = 0;
  bit          m_memwait    = 1'b0;
  int unsigned m_stall_cyc  = 0;
  int unsigned m_flush_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_match(input logic [4:0] r);
    return (r != 5'd0) && (r == bus.ID_rs || (bus.ID_UsesRt && r == bus.ID_rt));
  endfunction

  function automatic int m_need();
    int n = 0;
    if (bus.EX_MemRead && m_match(bus.EX_rt)) n = bus.ID_Branch ? 2 : 1;
    if (bus.ID_Branch && bus.EX_RegWrite && !bus.EX_MemRead && m_match(bus.EX_rd) && n < 1) n = 1;
    if (bus.ID_Branch && bus.MEM_MemRead && m_match(bus.MEM_rd) && n < 1) n = 1;
    return n;
  endfunction

  task automatic expect_now(input string tag);
    bit pc, ifid, bub, frz, fl;
    int st;
    st = m_memwait ? 2 : (m_stall_left > 0 ? 1 : 0);
    pc = 1; ifid = 1; bub = 0; frz = 0; fl = 0;
    if (!Reset) begin
      pc = 0; ifid = 0; bub = 1; st = 0;
    end else if (bus.Mem_Busy) begin
      pc = 0; ifid = 0; frz = 1;
    end else if (m_stall_left > 0 || m_need() > 0) begin
      pc = 0; ifid = 0; bub = 1;
    end else begin
      fl = bus.Branch_Taken | bus.Jump;
    end
    check_eq(tag, {25'd0, bus.PCWrite, bus.IF_ID_Write, bus.ID_EX_Bubble, bus.Pipe_Freeze,
                   bus.IF_Flush, bus.Stall_State},
             {25'd0, pc, ifid, bub, frz, fl, 2'(st)});
`ifdef HAZARD_PERF_CNT_EN
    check_eq({tag, "_stallcyc"}, bus.Stall_Cycles, Reset ? m_stall_cyc : 0);
    check_eq({tag, "_flushcnt"}, bus.Flush_Count, Reset ? m_flush_cnt : 0);
`endif
  endtask

  task automatic advance();
    int n;
    if (!Reset) begin
      m_stall_left = 0; m_memwait = 0; m_stall_cyc = 0; m_flush_cnt = 0;
    end else if (bus.Mem_Busy) begin
      m_memwait = 1; m_stall_cyc++;
    end else if (m_stall_left > 0) begin
      m_stall_left--; m_memwait = 0; m_stall_cyc++;
    end else begin
      m_memwait = 0;
      n = m_need();
      if (n > 0) begin
        m_stall_left = n - 1; m_stall_cyc++;
      end else if (bus.Branch_Taken || bus.Jump) begin
        m_flush_cnt++;
      end
    end
  endtask

  // Called at a negedge with inputs set; checks, crosses the posedge, returns at next negedge.
  task automatic cycle(input string tag);
    #1;
    expect_now(tag);
    @(posedge Clk);
    advance();
    @(negedge Clk);
  endtask

  task automatic set_idle();
    bus.ID_rs = 0; bus.ID_rt = 0; bus.ID_UsesRt = 0; bus.ID_Branch = 0;
    bus.Branch_Taken = 0; bus.Jump = 0; bus.EX_MemRead = 0; bus.EX_RegWrite = 0;
    bus.EX_rt = 0; bus.EX_rd = 0; bus.MEM_MemRead = 0; bus.MEM_rd = 0; bus.Mem_Busy = 0;
  endtask

  task automatic load_branch();
    set_idle();
    bus.EX_MemRead = 1; bus.EX_rt = 9; bus.ID_Branch = 1; bus.ID_rt = 9; bus.ID_UsesRt = 1;
  endtask

  initial begin
    Reset = 1'b0;
    set_idle();
    @(negedge Clk);
    #1;
    check_eq("rst_pcwrite", bus.PCWrite, 0);
    check_eq("rst_bubble", bus.ID_EX_Bubble, 1);
    check_eq("rst_state", bus.Stall_State, 0);
    cycle("rst");
    Reset = 1'b1;
    cycle("idle");

    // load-use, single stall
    bus.EX_MemRead = 1; bus.EX_rt = 8; bus.ID_rs = 8;
    #1;
    check_eq("lu_pcwrite", bus.PCWrite, 0);
    check_eq("lu_state", bus.Stall_State, 0);
    cycle("lu");
    bus.EX_MemRead = 0;
    #1;
    check_eq("lu_after_pcwrite", bus.PCWrite, 1);
    cycle("lu_after");

    // load feeding a branch: two stall cycles even when inputs drop
    load_branch();
    cycle("lb1");
    set_idle();
    #1;
    check_eq("lb2_state", bus.Stall_State, 1);
    check_eq("lb2_bubble", bus.ID_EX_Bubble, 1);
    cycle("lb2");
    #1;
    check_eq("lb3_state", bus.Stall_State, 0);
    check_eq("lb3_pcwrite", bus.PCWrite, 1);
    cycle("lb3");

    // ALU result feeding a branch, then a taken branch flush
    bus.EX_RegWrite = 1; bus.EX_rd = 10; bus.ID_Branch = 1; bus.ID_rs = 10;
    #1;
    check_eq("ba_bubble", bus.ID_EX_Bubble, 1);
    cycle("ba");
    bus.EX_RegWrite = 0; bus.Branch_Taken = 1;
    #1;
    check_eq("ba_flush", bus.IF_Flush, 1);
    cycle("ba_flush");
    set_idle();
    #1;
    check_eq("ba_noflush", bus.IF_Flush, 0);
    cycle("ba_idle");

    // $zero never hazards; jump flushes
    bus.EX_MemRead = 1; bus.EX_rt = 0; bus.ID_rs = 0; bus.Jump = 1;
    #1;
    check_eq("zero_pcwrite", bus.PCWrite, 1);
    check_eq("zero_flush", bus.IF_Flush, 1);
    cycle("zero");

    // memory busy arriving mid-stall
    load_branch();
    cycle("mw_enter_stall");
    set_idle();
    bus.Mem_Busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("mw_freeze%0d", i), bus.Pipe_Freeze, 1);
      cycle("mw_busy");
    end
    bus.Mem_Busy = 0;
    #1;
    check_eq("mw_resume_bubble", bus.ID_EX_Bubble, 1);
    check_eq("mw_resume_freeze", bus.Pipe_Freeze, 0);
    cycle("mw_resume");
    #1;
    check_eq("mw_run_pcwrite", bus.PCWrite, 1);
    cycle("mw_run");

    // asynchronous reset in the middle of a stall
    load_branch();
    cycle("rs_stall");
    set_idle();
    #2;
    Reset = 1'b0;
    #1;
    check_eq("rs_async_pcwrite", bus.PCWrite, 0);
    check_eq("rs_async_bubble", bus.ID_EX_Bubble, 1);
    check_eq("rs_async_state", bus.Stall_State, 0);
    cycle("rs_hold");
    Reset = 1'b1;
    #1;
    check_eq("rs_release_pcwrite", bus.PCWrite, 1);
    cycle("rs_release");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.ID_rs        = 5'($urandom_range(0, 3));
      bus.ID_rt        = 5'($urandom_range(0, 3));
      bus.ID_UsesRt    = 1'($urandom);
      bus.ID_Branch    = 1'($urandom);
      bus.Branch_Taken = ($urandom_range(0, 3) == 0);
      bus.Jump         = ($urandom_range(0, 5) == 0);
      bus.EX_MemRead   = 1'($urandom);
      bus.EX_RegWrite  = 1'($urandom);
      bus.EX_rt        = 5'($urandom_range(0, 3));
      bus.EX_rd        = 5'($urandom_range(0, 3));
      bus.MEM_MemRead  = 1'($urandom);
      bus.MEM_rd       = 5'($urandom_range(0, 3));
      bus.Mem_Busy     = ($urandom_range(0, 5) == 0);
      Reset            = ($urandom_range(0, 199) != 0);
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
